// File: rtl/d_write_buffer.sv
// Posted write buffer between a write-through D-cache and the memory port.
// Optional macro WB_READ_BYPASS_EN lets reads overtake queued stores to other words.
module d_write_buffer #(
   parameter int DEPTH   = 4,
   parameter int A_WIDTH = 32
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic [A_WIDTH-1:0] c_a,
   input  logic [31:0]        c_din,
   output logic [31:0]        c_dout,
   input  logic               c_strobe,
   input  logic               c_rw,
   input  logic [3:0]         c_wen,
   input  logic [1:0]         c_size,
   output logic               c_ready,
   output logic [A_WIDTH-1:0] mem_a,
   output logic [31:0]        mem_din,
   input  logic [31:0]        mem_dout,
   output logic               mem_strobe,
   output logic               mem_rw,
   output logic [3:0]         mem_wen,
   output logic [1:0]         mem_size,
   input  logic               mem_ready,
   output logic               wb_empty
);
   localparam int          PW       = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   state_t              state_q;
   logic [PW-1:0]       head_q;
   logic [PW-1:0]       tail_q;
   logic [PW:0]         count_q;
   logic [PW:0]         count_d;
   logic [A_WIDTH-1:0]  a_q    [DEPTH];
   logic [31:0]         d_q    [DEPTH];
   logic [3:0]          wen_q  [DEPTH];
   logic [1:0]          size_q [DEPTH];

   logic wr_acc_s;
   logic pop_s;
   logic rd_pend_s;
   logic rd_ok_s;

   // A full queue refuses the write even if the head retires this same cycle.
   assign wr_acc_s  = c_strobe & c_rw & (count_q != CNT_FULL);
   assign pop_s     = (state_q == WRITE) & mem_ready;
   assign rd_pend_s = c_strobe & ~c_rw;

`ifdef WB_READ_BYPASS_EN
   logic hit_s;

   // Word-address match of the pending read against every live queue entry.
   always_comb begin
      logic [PW-1:0] off;
      hit_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PW'(i) - head_q;
         if (({1'b0, off} < count_q) && (a_q[i][A_WIDTH-1:2] == c_a[A_WIDTH-1:2])) begin
            hit_s = 1'b1;
         end else begin
            hit_s = hit_s;
         end
      end
   end

   assign rd_ok_s = ~hit_s & (c_a[31:16] != 16'hffff);
`else
   assign rd_ok_s = (count_q == '0);
`endif

   // Occupancy next state: a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      if (wr_acc_s & ~pop_s) begin
         count_d = count_q + CNT_ONE;
      end else if (pop_s & ~wr_acc_s) begin
         count_d = count_q - CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Pointers, occupancy and the memory-port sequencer.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (wr_acc_s) tail_q <= tail_q + PTR_ONE;
         if (pop_s)    head_q <= head_q + PTR_ONE;
         count_q <= count_d;
         case (state_q)
            IDLE: begin
               if (rd_pend_s & rd_ok_s)   state_q <= READ;
               else if (count_q != '0)    state_q <= WRITE;
               else                       state_q <= IDLE;
            end
            WRITE:   state_q <= mem_ready ? IDLE : WRITE;
            READ:    state_q <= mem_ready ? IDLE : READ;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Queue storage; contents are only meaningful inside the head..tail window.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         a_q[tail_q]    <= c_a;
         d_q[tail_q]    <= c_din;
         wen_q[tail_q]  <= c_wen;
         size_q[tail_q] <= c_size;
      end
   end

   assign mem_strobe = (state_q != IDLE);
   assign mem_rw     = (state_q == WRITE);
   assign mem_a      = (state_q == READ) ? c_a    : a_q[head_q];
   assign mem_wen    = (state_q == READ) ? c_wen  : wen_q[head_q];
   assign mem_size   = (state_q == READ) ? c_size : size_q[head_q];
   assign mem_din    = d_q[head_q];
   assign c_ready    = wr_acc_s | ((state_q == READ) & mem_ready);
   assign c_dout     = mem_dout;
   assign wb_empty   = (count_q == '0) & (state_q != WRITE);

endmodule

// File: tb/tb_d_write_buffer.sv
// Directed and randomized bench for d_write_buffer; honours WB_READ_BYPASS_EN when defined.
module tb_d_write_buffer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        clrn;
   logic [31:0] c_a, c_din, c_dout, mem_a, mem_din, mem_dout;
   logic        c_strobe, c_rw, c_ready, mem_strobe, mem_rw, mem_ready, wb_empty;
   logic [3:0]  c_wen, mem_wen;
   logic [1:0]  c_size, mem_size;

   int nvec = 0;
   int nerr = 0;

   logic [31:0] q_a [$];
   logic [31:0] q_d [$];
   logic [3:0]  q_w [$];
   logic [1:0]  q_s [$];

   d_write_buffer #(.DEPTH(DEPTH), .A_WIDTH(32)) dut (
      .clk(clk), .clrn(clrn),
      .c_a(c_a), .c_din(c_din), .c_dout(c_dout), .c_strobe(c_strobe), .c_rw(c_rw),
      .c_wen(c_wen), .c_size(c_size), .c_ready(c_ready),
      .mem_a(mem_a), .mem_din(mem_din), .mem_dout(mem_dout), .mem_strobe(mem_strobe),
      .mem_rw(mem_rw), .mem_wen(mem_wen), .mem_size(mem_size), .mem_ready(mem_ready),
      .wb_empty(wb_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w, input logic [1:0] s);
      c_strobe = 1'b1; c_rw = 1'b1; c_a = a; c_din = d; c_wen = w; c_size = s;
   endtask

   task automatic drive_rd(input logic [31:0] a);
      c_strobe = 1'b1; c_rw = 1'b0; c_a = a; c_wen = 4'hF; c_size = 2'b10;
   endtask

   // Waits (bounded) for the next memory write, checks it, and completes it.
   task automatic expect_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] w, input logic [1:0] s);
      int k = 0;
      sample();
      while (!(mem_strobe && mem_rw) && k < 20) begin
         tick();
         sample();
         k++;
      end
      chk($sformatf("%s_strobe", tag), mem_strobe && mem_rw, 1'b1);
      chk($sformatf("%s_a", tag), mem_a, a);
      chk($sformatf("%s_din", tag), mem_din, d);
      chk($sformatf("%s_wen", tag), {28'd0, mem_wen}, {28'd0, w});
      chk($sformatf("%s_size", tag), {30'd0, mem_size}, {30'd0, s});
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
   endtask

   function automatic bit read_allowed(input logic [31:0] a);
`ifdef WB_READ_BYPASS_EN
      foreach (q_a[i]) if (q_a[i][31:2] == a[31:2]) return 1'b0;
      return (a[31:16] != 16'hFFFF);
`else
      return (q_a.size() == 0);
`endif
   endfunction

   function automatic logic [31:0] pick_addr();
      logic [31:0] base;
      case ($urandom_range(0, 4))
         0:       base = 32'h0000_0100;
         1:       base = 32'h0000_0104;
         2:       base = 32'h0000_0108;
         3:       base = 32'hFFFF_0000;
         default: base = 32'h0000_0200;
      endcase
      return base | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      bit req, req_rw;
      int hold, occ;
      clrn = 1'b0; c_strobe = 1'b0; c_rw = 1'b0; c_a = 32'd0; c_din = 32'd0;
      c_wen = 4'd0; c_size = 2'd0; mem_dout = 32'd0; mem_ready = 1'b0;
      req = 1'b0; req_rw = 1'b0; hold = 0;

      // Reset state; a write to the empty queue is still acknowledged combinationally
      #2;
      chk("rst_strobe", mem_strobe, 1'b0);
      chk("rst_empty", wb_empty, 1'b1);
      chk("rst_ready_idle", c_ready, 1'b0);
      c_strobe = 1'b1; c_rw = 1'b1;
      #1 chk("rst_ready_wr", c_ready, 1'b1);
      c_strobe = 1'b0;
      tick();
      clrn = 1'b1;

      // Single write: zero-latency accept, one bubble, then a 3-cycle memory write
      tick(); drive_wr(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 2'b10);
      sample(); chk("sw_ready", c_ready, 1'b1); chk("sw_empty_before", wb_empty, 1'b1);
      tick(); c_strobe = 1'b0;
      sample(); chk("sw_bubble", mem_strobe, 1'b0); chk("sw_not_empty", wb_empty, 1'b0);
      tick(); sample();
      chk("sw_strobe", mem_strobe, 1'b1); chk("sw_rw", mem_rw, 1'b1);
      chk("sw_a", mem_a, 32'h0000_1000); chk("sw_din", mem_din, 32'hDEAD_BEEF);
      tick(); sample(); chk("sw_hold", mem_strobe, 1'b1);
      tick(); mem_ready = 1'b1; sample(); chk("sw_empty_busy", wb_empty, 1'b0);
      tick(); mem_ready = 1'b0; sample();
      chk("sw_empty_after", wb_empty, 1'b1); chk("sw_idle_after", mem_strobe, 1'b0);

      // Full queue: fifth write stalls, a same-cycle pop does not free a slot
      for (int i = 0; i < 4; i++) begin
         tick(); drive_wr(32'h0000_5000 + 32'(4 * i), 32'h0000_00A0 + 32'(i), 4'hF, 2'b10);
         sample(); chk("full_acc", c_ready, 1'b1);
      end
      tick(); drive_wr(32'h0000_5010, 32'h0000_00A4, 4'hF, 2'b10);
      sample(); chk("full_stall1", c_ready, 1'b0);
      tick(); sample(); chk("full_stall2", c_ready, 1'b0);
      tick(); mem_ready = 1'b1; sample();
      chk("full_pop_same", c_ready, 1'b0); chk("full_head_a", mem_a, 32'h0000_5000);
      tick(); mem_ready = 1'b0; sample(); chk("full_acc5", c_ready, 1'b1);
      tick(); c_strobe = 1'b0;
      for (int i = 1; i < 5; i++)
         expect_write("full_drain", 32'h0000_5000 + 32'(4 * i), 32'h0000_00A0 + 32'(i), 4'hF, 2'b10);

      // Read after write to the same word waits for the write to finish
      tick(); drive_wr(32'h0000_2000, 32'h1122_3344, 4'hF, 2'b10);
      sample(); chk("raw_wr_ready", c_ready, 1'b1);
      tick(); drive_rd(32'h0000_2000);
      sample(); chk("raw_rd_wait", c_ready, 1'b0);
      tick(); sample();
      chk("raw_write_first", mem_rw, 1'b1); chk("raw_write_a", mem_a, 32'h0000_2000);
      mem_ready = 1'b1;
      tick(); mem_ready = 1'b0; sample();
      chk("raw_bubble", mem_strobe, 1'b0); chk("raw_no_ready", c_ready, 1'b0);
      tick(); sample();
      chk("raw_read_strobe", mem_strobe, 1'b1); chk("raw_read_rw", mem_rw, 1'b0);
      chk("raw_read_a", mem_a, 32'h0000_2000); chk("raw_read_notyet", c_ready, 1'b0);
      tick(); sample(); mem_ready = 1'b1; mem_dout = 32'hCAFE_0001;
      #1 chk("raw_read_ready", c_ready, 1'b1); chk("raw_read_dout", c_dout, 32'hCAFE_0001);
      tick(); c_strobe = 1'b0; mem_ready = 1'b0;

      // Read to a different word with a store still queued
      tick(); drive_wr(32'h0000_3000, 32'h0000_3333, 4'hF, 2'b10);
      sample(); chk("byp_wr_ready", c_ready, 1'b1);
      tick(); drive_rd(32'h0000_4000);
      sample();
      tick(); sample();
`ifdef WB_READ_BYPASS_EN
      chk("byp_read_first", mem_rw, 1'b0); chk("byp_read_a", mem_a, 32'h0000_4000);
      mem_ready = 1'b1;
      #1 chk("byp_read_ready", c_ready, 1'b1);
      tick(); mem_ready = 1'b0; drive_rd(32'hFFFF_0010);
      sample(); chk("io_wait", c_ready, 1'b0);
      tick(); sample();
      chk("io_drain_first", mem_rw, 1'b1); chk("io_drain_a", mem_a, 32'h0000_3000);
      mem_ready = 1'b1;
      tick(); mem_ready = 1'b0; sample(); chk("io_empty", wb_empty, 1'b1);
      tick(); sample();
      chk("io_read_rw", mem_rw, 1'b0); chk("io_read_a", mem_a, 32'hFFFF_0010);
      mem_ready = 1'b1;
      #1 chk("io_read_ready", c_ready, 1'b1);
`else
      chk("nobyp_drain_first", mem_rw, 1'b1); chk("nobyp_drain_a", mem_a, 32'h0000_3000);
      mem_ready = 1'b1;
      tick(); mem_ready = 1'b0; sample(); chk("nobyp_empty", wb_empty, 1'b1);
      tick(); sample();
      chk("nobyp_read_rw", mem_rw, 1'b0); chk("nobyp_read_a", mem_a, 32'h0000_4000);
      mem_ready = 1'b1;
      #1 chk("nobyp_read_ready", c_ready, 1'b1);
`endif
      tick(); c_strobe = 1'b0; mem_ready = 1'b0;

      // Byte write: enables and size pass through on drain
      tick(); drive_wr(32'h0000_6001, 32'h0000_AB00, 4'b0010, 2'b00);
      sample(); chk("byte_ready", c_ready, 1'b1);
      tick(); c_strobe = 1'b0;
      expect_write("byte", 32'h0000_6001, 32'h0000_AB00, 4'b0010, 2'b00);

      // Reset in the middle of a drain discards the queue
      for (int i = 0; i < 3; i++) begin
         tick(); drive_wr(32'h0000_7000 + 32'(4 * i), 32'(i), 4'hF, 2'b10);
         sample(); chk("rmd_acc", c_ready, 1'b1);
      end
      tick(); c_strobe = 1'b0;
      sample(); chk("rmd_busy", mem_strobe, 1'b1);
      #2 clrn = 1'b0;
      #1 chk("rmd_strobe", mem_strobe, 1'b0); chk("rmd_empty", wb_empty, 1'b1);
      tick(); clrn = 1'b1; mem_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sample(); chk("rmd_no_write", mem_strobe, 1'b0);
         tick();
      end
      mem_ready = 1'b0;

      // Randomized traffic against a transaction-level queue model
      for (int n = 0; n < 3000; n++) begin
         tick();
         if (!req && $urandom_range(0, 3) != 0) begin
            req = 1'b1; req_rw = ($urandom_range(0, 1) == 1); hold = 0;
            c_a = pick_addr(); c_din = $urandom; c_wen = 4'($urandom); c_size = 2'($urandom);
         end
         c_strobe = req; c_rw = req_rw;
         mem_ready = ($urandom_range(0, 2) == 0); mem_dout = $urandom;
         sample();
         occ = q_a.size();
         chk("rnd_empty", wb_empty, occ == 0);
         if (mem_strobe && mem_rw) begin
            chk("rnd_wr_valid", occ > 0, 1'b1);
            if (occ > 0) begin
               chk("rnd_wr_a", mem_a, q_a[0]);
               chk("rnd_wr_din", mem_din, q_d[0]);
               chk("rnd_wr_wen", {28'd0, mem_wen}, {28'd0, q_w[0]});
               chk("rnd_wr_size", {30'd0, mem_size}, {30'd0, q_s[0]});
            end
         end
         if (mem_strobe && !mem_rw) begin
            chk("rnd_rd_req", req && !req_rw, 1'b1);
            chk("rnd_rd_a", mem_a, c_a);
            chk("rnd_rd_wen", {28'd0, mem_wen}, {28'd0, c_wen});
            chk("rnd_rd_order", read_allowed(c_a), 1'b1);
         end
         if (req) begin
            if (req_rw) begin
               chk("rnd_wr_ready", c_ready, occ < DEPTH);
            end else begin
               chk("rnd_rd_ready", c_ready, mem_strobe && !mem_rw && mem_ready);
               chk("rnd_rd_dout", c_dout, mem_dout);
            end
         end
         if (mem_strobe && mem_rw && mem_ready && occ > 0) begin
            void'(q_a.pop_front()); void'(q_d.pop_front());
            void'(q_w.pop_front()); void'(q_s.pop_front());
         end
         if (req && req_rw && occ < DEPTH) begin
            q_a.push_back(c_a); q_d.push_back(c_din); q_w.push_back(c_wen); q_s.push_back(c_size);
         end
         if (req) begin
            if (c_ready) begin
               req = 1'b0;
            end else begin
               hold++;
               chk("rnd_timeout", hold < 200, 1'b1);
               if (hold >= 200) req = 1'b0;
            end
         end
      end
      tick(); c_strobe = 1'b0; mem_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
